// File: rtl/bram_pkg.sv
// Shared definitions for the byte-write true dual-port RAM: write-mode codes,
// address-width helper and the byte-lane merge used for writes and WRITE_FIRST data.
package bram_pkg;

   localparam int WM_READ_FIRST  = 0;
   localparam int WM_WRITE_FIRST = 1;
   localparam int WM_NO_CHANGE   = 2;

   // Widest word the merge helper handles; callers zero-pad narrower words.
   localparam int MERGE_MAX_W   = 256;
   localparam int MERGE_IDX_W   = 8;

   function automatic int clogb2(input int value);
      int v;
      int r;
      v = value;
      r = 0;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      if (r < 1) r = 1;
      return r;
   endfunction

   function automatic int mode_code(input string m);
      if (m == "WRITE_FIRST") return WM_WRITE_FIRST;
      if (m == "NO_CHANGE")   return WM_NO_CHANGE;
      return WM_READ_FIRST;
   endfunction

   // Per bit: take the new word where the owning byte lane is enabled.
   function automatic logic [MERGE_MAX_W-1:0] byte_merge(
      input logic [MERGE_MAX_W-1:0] old_w,
      input logic [MERGE_MAX_W-1:0] new_w,
      input logic [MERGE_MAX_W-1:0] we,
      input int                     byte_w
   );
      logic [MERGE_MAX_W-1:0] merged;
      merged = old_w;
      for (int i = 0; i < MERGE_MAX_W; i++) begin
         if (we[MERGE_IDX_W'(i / byte_w)]) merged[MERGE_IDX_W'(i)] = new_w[MERGE_IDX_W'(i)];
      end
      return merged;
   endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Read-data and read-valid pipeline for one RAM port; READ_LATENCY of 1 or 2.
module bram_rd_pipe #(
   parameter int RAM_WIDTH    = 64,
   parameter int READ_LATENCY = 1
) (
   input  logic                 clka,
   input  logic                 rst,
   input  logic                 rd_vld,
   input  logic [RAM_WIDTH-1:0] rd_data,
   output logic [RAM_WIDTH-1:0] dout,
   output logic                 rvalid
);

   logic [RAM_WIDTH-1:0] data_p1;
   logic                 vld_p1;

   // Stage 1: capture the array read; data holds when no read is accepted.
   always_ff @(posedge clka) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
      end else begin
         vld_p1 <= rd_vld;
         if (rd_vld) data_p1 <= rd_data;
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic [RAM_WIDTH-1:0] data_p2;
      logic                 vld_p2;

      // Stage 2: optional output register.
      always_ff @(posedge clka) begin
         if (rst) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
         end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) data_p2 <= data_p1;
         end
      end

      assign dout   = data_p2;
      assign rvalid = vld_p2;
   end else begin : g_lat1
      assign dout   = data_p1;
      assign rvalid = vld_p1;
   end

endmodule

// File: rtl/truedual_bytewrite_bram.sv
// Single-clock true dual-port RAM with byte enables, per-port write modes and read pipelines.
// Define TRUEDUAL_BRAM_COLLISION_CHECK_EN to get the registered same-address collision flags.
module truedual_bytewrite_bram
   import bram_pkg::*;
#(
   parameter int    RAM_WIDTH    = 64,
   parameter int    BYTE_WIDTH   = 8,
   parameter int    RAM_DEPTH    = 1024,
   parameter int    READ_LATENCY = 1,
   parameter string WRITE_MODE_A = "READ_FIRST",
   parameter string WRITE_MODE_B = "READ_FIRST",
   parameter string INIT_FILE    = "",
   localparam int   NB           = RAM_WIDTH / BYTE_WIDTH,
   localparam int   ADDR_W       = clogb2(RAM_DEPTH - 1)
) (
   input  logic                 clka,
   input  logic                 rst,
   input  logic                 ena,
   input  logic [NB-1:0]        wea,
   input  logic [ADDR_W-1:0]    addra,
   input  logic [RAM_WIDTH-1:0] dina,
   output logic [RAM_WIDTH-1:0] douta,
   output logic                 rvalida,
   input  logic                 enb,
   input  logic [NB-1:0]        web,
   input  logic [ADDR_W-1:0]    addrb,
   input  logic [RAM_WIDTH-1:0] dinb,
   output logic [RAM_WIDTH-1:0] doutb,
   output logic                 rvalidb,
   output logic [1:0]           collision
);

   localparam int MODE_A = mode_code(WRITE_MODE_A);
   localparam int MODE_B = mode_code(WRITE_MODE_B);

   logic [RAM_WIDTH-1:0] mem [0:RAM_DEPTH-1];

   initial begin
      for (int i = 0; i < RAM_DEPTH; i++) mem[i] = '0;
   end

   function automatic logic [RAM_WIDTH-1:0] merge_w(
      input logic [RAM_WIDTH-1:0] o,
      input logic [RAM_WIDTH-1:0] n,
      input logic [NB-1:0]        w
   );
      logic [MERGE_MAX_W-1:0] ox, nx, wx, mx;
      ox = '0;
      nx = '0;
      wx = '0;
      ox[RAM_WIDTH-1:0] = o;
      nx[RAM_WIDTH-1:0] = n;
      wx[NB-1:0]        = w;
      mx = byte_merge(ox, nx, wx, BYTE_WIDTH);
      return mx[RAM_WIDTH-1:0];
   endfunction

   logic                 in_a, in_b, same, wr_a, wr_b, rd_a, rd_b;
   logic [RAM_WIDTH-1:0] old_a, old_b, mrg_a, mrg_b, mrg_ab, rdata_a, rdata_b;

   assign in_a   = (int'(addra) < RAM_DEPTH);
   assign in_b   = (int'(addrb) < RAM_DEPTH);
   assign old_a  = in_a ? mem[addra] : '0;
   assign old_b  = in_b ? mem[addrb] : '0;
   assign same   = ena && enb && (addra == addrb);
   assign wr_a   = ena && !rst && (|wea) && in_a;
   assign wr_b   = enb && !rst && (|web) && in_b;
   assign mrg_a  = merge_w(old_a, dina, wea);
   assign mrg_b  = merge_w(old_b, dinb, web);
   // Port B's bytes first, port A laid on top, so A wins overlapping lanes.
   assign mrg_ab = merge_w(mrg_b, dina, wea);

   always_ff @(posedge clka) begin
      if (wr_b && !(wr_a && same)) mem[addrb] <= mrg_b;
      if (wr_a) mem[addra] <= (wr_b && same) ? mrg_ab : mrg_a;
   end

   // Each port's read data is built from the pre-cycle word, never the other port's write.
   assign rd_a    = ena && !rst && !((|wea) && (MODE_A == WM_NO_CHANGE));
   assign rd_b    = enb && !rst && !((|web) && (MODE_B == WM_NO_CHANGE));
   assign rdata_a = ((|wea) && (MODE_A == WM_WRITE_FIRST) && in_a) ? mrg_a : old_a;
   assign rdata_b = ((|web) && (MODE_B == WM_WRITE_FIRST) && in_b) ? mrg_b : old_b;

   bram_rd_pipe #(
      .RAM_WIDTH   (RAM_WIDTH),
      .READ_LATENCY(READ_LATENCY)
   ) u_pipe_a (
      .clka   (clka),
      .rst    (rst),
      .rd_vld (rd_a),
      .rd_data(rdata_a),
      .dout   (douta),
      .rvalid (rvalida)
   );

   bram_rd_pipe #(
      .RAM_WIDTH   (RAM_WIDTH),
      .READ_LATENCY(READ_LATENCY)
   ) u_pipe_b (
      .clka   (clka),
      .rst    (rst),
      .rd_vld (rd_b),
      .rd_data(rdata_b),
      .dout   (doutb),
      .rvalid (rvalidb)
   );

`ifdef TRUEDUAL_BRAM_COLLISION_CHECK_EN
   logic [1:0] collision_p1;

   always_ff @(posedge clka) begin
      if (rst) begin
         collision_p1 <= 2'b00;
      end else begin
         collision_p1[0] <= same && (|(wea & web));
         collision_p1[1] <= same && ((|wea) != (|web));
      end
   end

   assign collision = collision_p1;
`else
   assign collision = 2'b00;
`endif

endmodule
